// File: rtl/wb_stage_buf.sv
// ============================================================================
// wb_stage_buf : in-order writeback retire queue with RF backpressure,
//                forwarding lookups, flush and retire trace.   Rev 1.0
// ============================================================================
`default_nettype none

module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int NFWD   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MEM_to_WB_valid,
  input  logic [2*DATA_W+ADDR_W:0]     to_WB_data,
  output logic                         WB_allow_in,
  input  logic                         flush,
  input  logic                         rf_ready,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic [NFWD*ADDR_W-1:0]       fwd_raddr,
  output logic [NFWD-1:0]              fwd_hit,
  output logic [NFWD*DATA_W-1:0]       fwd_data,
  output logic [$clog2(DEPTH):0]       wb_count,
  output logic [DATA_W-1:0]            debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_we,
  output logic [ADDR_W-1:0]            debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, we_q, we_d;
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] pc_d   [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic [DATA_W-1:0] res_d  [DEPTH];
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [ADDR_W-1:0] dest_d [DEPTH];

  logic [DATA_W-1:0] in_pc, in_res;
  logic [ADDR_W-1:0] in_dest;
  logic              in_we;

  assign in_we   = to_WB_data[0];
  assign in_res  = to_WB_data[DATA_W:1];
  assign in_dest = to_WB_data[DATA_W+ADDR_W:DATA_W+1];
  assign in_pc   = to_WB_data[2*DATA_W+ADDR_W:DATA_W+ADDR_W+1];

  logic head_valid, head_elig, retire, enq;

  // Reset is gated in too so a stalled head cannot write during the reset cycle.
  assign head_valid  = valid_q[head_q];
  assign head_elig   = head_valid && we_q[head_q] && (dest_q[head_q] != '0);
  assign rf_we       = head_elig && !flush && !reset;
  assign retire      = head_valid && !flush && !reset && (!head_elig || rf_ready);
  assign WB_allow_in = (count_q < C_DEPTH) || retire;
  assign enq         = MEM_to_WB_valid && WB_allow_in && !flush && !reset;

  assign rf_waddr          = dest_q[head_q];
  assign rf_wdata          = res_q[head_q];
  assign wb_count          = count_q;
  assign debug_wb_pc       = pc_q[head_q];
  assign debug_wb_rf_wnum  = dest_q[head_q];
  assign debug_wb_rf_wdata = res_q[head_q];
  assign debug_wb_rf_we    = {4{retire && rf_we && rf_ready}};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    we_d    = we_q;
    pc_d    = pc_q;
    res_d   = res_q;
    dest_d  = dest_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      // On a full queue head==tail; the enqueue below must win the valid bit.
      if (retire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      if (enq) begin
        valid_d[tail_q] = 1'b1;
        we_d[tail_q]    = in_we;
        pc_d[tail_q]    = in_pc;
        res_d[tail_q]   = in_res;
        dest_d[tail_q]  = in_dest;
        tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(retire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
    we_q   <= we_d;
    pc_q   <= pc_d;
    res_q  <= res_d;
    dest_q <= dest_d;
  end

  // Scan oldest to youngest so the last match (closest to tail) wins.
  for (genvar gi = 0; gi < NFWD; gi++) begin : g_fwd
    logic [ADDR_W-1:0] raddr;
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  idx;

    assign raddr = fwd_raddr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + PTR_W'(k);
        if (valid_q[idx] && we_q[idx] && (dest_q[idx] == raddr) && (raddr != '0)) begin
          hit  = 1'b1;
          data = res_q[idx];
        end
      end
    end

    assign fwd_hit[gi]                  = hit;
    assign fwd_data[gi*DATA_W +: DATA_W] = data;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_buf.sv
// ============================================================================
// tb_wb_stage_buf : directed vector table plus multi-cycle sequences.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [69:0] to_wb_data;
  logic        allow_in;
  logic        flush;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [9:0]  fwd_raddr;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic [2:0]  wb_count;
  logic [31:0] dbg_pc;
  logic [3:0]  dbg_we;
  logic [4:0]  dbg_wnum;
  logic [31:0] dbg_wdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_stage_buf #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .NFWD(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .MEM_to_WB_valid   (mem_valid),
    .to_WB_data        (to_wb_data),
    .WB_allow_in       (allow_in),
    .flush             (flush),
    .rf_ready          (rf_ready),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_raddr         (fwd_raddr),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data),
    .wb_count          (wb_count),
    .debug_wb_pc       (dbg_pc),
    .debug_wb_rf_we    (dbg_we),
    .debug_wb_rf_wnum  (dbg_wnum),
    .debug_wb_rf_wdata (dbg_wdata)
  );

  typedef struct {
    logic        rst, vld;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        we, fl, rdy;
    logic [4:0]  ra0, ra1;
    logic        e_allow, e_rfwe;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_dbg;
    logic [2:0]  e_cnt;
    logic [1:0]  e_hit;
    logic [31:0] e_fd0;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, vld, input logic [31:0] pc, input logic [4:0] dest,
                     input logic [31:0] res, input logic we, fl, rdy, input logic [4:0] ra0, ra1,
                     input logic e_allow, e_rfwe, input logic [4:0] e_waddr, input logic [31:0] e_wdata,
                     input logic [3:0] e_dbg, input logic [2:0] e_cnt, input logic [1:0] e_hit,
                     input logic [31:0] e_fd0);
    vec_t v;
    v.rst = rst; v.vld = vld; v.pc = pc; v.dest = dest; v.res = res; v.we = we;
    v.fl = fl; v.rdy = rdy; v.ra0 = ra0; v.ra1 = ra1;
    v.e_allow = e_allow; v.e_rfwe = e_rfwe; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_dbg = e_dbg; v.e_cnt = e_cnt; v.e_hit = e_hit; v.e_fd0 = e_fd0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, vld, input logic [31:0] pc, input logic [4:0] dest,
                       input logic [31:0] res, input logic we, fl, rdy, input logic [4:0] ra0, ra1);
    reset      = rst;
    mem_valid  = vld;
    to_wb_data = {pc, dest, res, we};
    flush      = fl;
    rf_ready   = rdy;
    fwd_raddr  = {ra1, ra0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int writes;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   rst vld pc           dest res           we fl rdy ra0 ra1 | allow rfwe waddr wdata        dbg   cnt hit    fd0
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);        // reset state
    add(0, 1, 32'h1c000000, 3,  32'hDEADBEEF, 1, 0, 1, 3,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 3,  0,  1, 1, 3,  32'hDEADBEEF, 4'hF, 1, 2'b01, 32'hDEADBEEF);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 3,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    // fill and backpressure
    add(0, 1, 32'h10,       1,  32'h101,      1, 0, 0, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    add(0, 1, 32'h14,       2,  32'h102,      1, 0, 0, 0,  0,  1, 1, 1,  32'h101,      4'h0, 1, 2'b00, 32'h0);
    add(0, 1, 32'h18,       3,  32'h103,      1, 0, 0, 0,  0,  1, 1, 1,  32'h101,      4'h0, 2, 2'b00, 32'h0);
    add(0, 1, 32'h1c,       4,  32'h104,      1, 0, 0, 0,  0,  1, 1, 1,  32'h101,      4'h0, 3, 2'b00, 32'h0);
    add(0, 1, 32'h20,       5,  32'h105,      1, 0, 0, 2,  5,  0, 1, 1,  32'h101,      4'h0, 4, 2'b01, 32'h102);
    add(0, 1, 32'h20,       5,  32'h105,      1, 0, 1, 0,  0,  1, 1, 1,  32'h101,      4'hF, 4, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 5,  0,  1, 1, 2,  32'h102,      4'hF, 4, 2'b01, 32'h105);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 1, 3,  32'h103,      4'hF, 3, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 1, 4,  32'h104,      4'hF, 2, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 1, 5,  32'h105,      4'hF, 1, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    // forwarding youngest, dest-0 entry never forwards
    add(0, 1, 32'h30,       7,  32'h11,       1, 0, 0, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    add(0, 1, 32'h34,       7,  32'h22,       1, 0, 0, 7,  0,  1, 1, 7,  32'h11,       4'h0, 1, 2'b01, 32'h11);
    add(0, 1, 32'h38,       0,  32'h33,       1, 0, 0, 7,  0,  1, 1, 7,  32'h11,       4'h0, 2, 2'b01, 32'h22);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 0, 7,  0,  1, 1, 7,  32'h11,       4'h0, 3, 2'b01, 32'h22);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 7,  0,  1, 1, 7,  32'h11,       4'hF, 3, 2'b01, 32'h22);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 7,  0,  1, 1, 7,  32'h22,       4'hF, 2, 2'b01, 32'h22);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 7,  0,  1, 0, 0,  32'h0,        4'h0, 1, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    // non-writing entries retire without rf_ready
    add(0, 1, 32'h100,      9,  32'hAA,       0, 0, 0, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    add(0, 1, 32'h104,      0,  32'hBB,       1, 0, 0, 9,  0,  1, 0, 0,  32'h0,        4'h0, 1, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 0, 0,  0,  1, 0, 0,  32'h0,        4'h0, 1, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 0, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    // flush with concurrent offer
    add(0, 1, 32'h200,      10, 32'hA0,       1, 0, 0, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    add(0, 1, 32'h204,      11, 32'hA1,       1, 0, 0, 0,  0,  1, 1, 10, 32'hA0,       4'h0, 1, 2'b00, 32'h0);
    add(0, 1, 32'h208,      12, 32'hA2,       1, 0, 0, 0,  0,  1, 1, 10, 32'hA0,       4'h0, 2, 2'b00, 32'h0);
    add(0, 1, 32'h20c,      13, 32'hA3,       1, 1, 1, 0,  0,  1, 0, 0,  32'h0,        4'h0, 3, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 13, 12, 1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    // reset mid-stall
    add(0, 1, 32'h300,      20, 32'hC0,       1, 0, 0, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    add(0, 1, 32'h304,      21, 32'hC1,       1, 0, 0, 0,  0,  1, 1, 20, 32'hC0,       4'h0, 1, 2'b00, 32'h0);
    add(1, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 0, 0,  32'h0,        4'h0, 2, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 20, 21, 1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);
    add(0, 0, 32'h0,        0,  32'h0,        0, 0, 1, 0,  0,  1, 0, 0,  32'h0,        4'h0, 0, 2'b00, 32'h0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rst, vecs[i].vld, vecs[i].pc, vecs[i].dest, vecs[i].res,
            vecs[i].we, vecs[i].fl, vecs[i].rdy, vecs[i].ra0, vecs[i].ra1);
      #3;
      chk($sformatf("row%0d_allow", i), 64'(allow_in), 64'(vecs[i].e_allow));
      chk($sformatf("row%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].e_rfwe));
      chk($sformatf("row%0d_dbg_we", i), 64'(dbg_we), 64'(vecs[i].e_dbg));
      chk($sformatf("row%0d_count", i), 64'(wb_count), 64'(vecs[i].e_cnt));
      chk($sformatf("row%0d_fwd_hit", i), 64'(fwd_hit), 64'(vecs[i].e_hit));
      if (vecs[i].e_rfwe) begin
        chk($sformatf("row%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].e_waddr));
        chk($sformatf("row%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].e_wdata));
      end
      if (vecs[i].e_hit[0])
        chk($sformatf("row%0d_fwd_data0", i), 64'(fwd_data[31:0]), 64'(vecs[i].e_fd0));
    end

    // Debug trace fields and forwarding on port 1.
    @(posedge clk); #1;
    drive(0, 1, 32'h1c000000, 3, 32'hDEADBEEF, 1, 0, 1, 0, 3);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    #3;
    chk("h1_dbg_pc", 64'(dbg_pc), 64'h1c000000);
    chk("h1_dbg_wnum", 64'(dbg_wnum), 64'd3);
    chk("h1_dbg_wdata", 64'(dbg_wdata), 64'hDEADBEEF);
    chk("h1_dbg_we", 64'(dbg_we), 64'hF);
    chk("h1_fwd_hit1", 64'(fwd_hit[1]), 64'd1);
    chk("h1_fwd_data1", 64'(fwd_data[63:32]), 64'hDEADBEEF);

    // Stalled head holds its outputs, then writes exactly once.
    @(posedge clk); #1;
    drive(0, 1, 32'h400, 6, 32'h66, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #3;
      chk($sformatf("h2_hold%0d_we", c), 64'(rf_we), 64'd1);
      chk($sformatf("h2_hold%0d_addr", c), 64'(rf_waddr), 64'd6);
      chk($sformatf("h2_hold%0d_data", c), 64'(rf_wdata), 64'h66);
      chk($sformatf("h2_hold%0d_dbg", c), 64'(dbg_we), 64'h0);
      @(posedge clk); #1;
    end
    rf_ready = 1'b1;
    writes = 0;
    for (int c = 0; c < 5; c++) begin
      #3;
      if (dbg_we == 4'hF) writes++;
      @(posedge clk); #1;
    end
    chk("h2_one_write", 64'(writes), 64'd1);
    chk("h2_count", 64'(wb_count), 64'd0);

    // Flush together with reset behaves as reset.
    drive(0, 1, 32'h500, 8, 32'h88, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 1, 32'h504, 9, 32'h99, 1, 1, 0, 8, 0);
    #3;
    chk("h3_rf_we_in_reset", 64'(rf_we), 64'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 8, 9);
    #3;
    chk("h3_count", 64'(wb_count), 64'd0);
    chk("h3_rf_we", 64'(rf_we), 64'd0);
    chk("h3_allow", 64'(allow_in), 64'd1);
    chk("h3_fwd_hit", 64'(fwd_hit), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage_buf.md
Name: wb_stage_buf

Overview:
- Parametrised successor to the single-register writeback stage: decouples MEM from the register-file write port with a DEPTH-entry in-order retire queue.
- The RF port may be shared (rf_ready backpressure), so MEM keeps flowing while RF writes stall.
- Provides NFWD combinational forwarding lookups over pending writes, a synchronous flush and per-retire debug trace.
- Sits between MEM_stage and the regfile.

Parameters:
- DATA_W, 32, width of result and pc.
- ADDR_W, 5, register address width.
- DEPTH, 4, queue entries; power of 2, >=2.
- NFWD, 2, number of forwarding lookup ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- MEM_to_WB_valid  in  1  MEM offers an entry
- to_WB_data  in  2*DATA_W+ADDR_W+1  {pc, dest, final_result, gr_we}, pc in MSBs, gr_we in LSB
- WB_allow_in  out  1  queue can accept this cycle
- flush  in  1  discard all pending entries
- rf_ready  in  1  regfile port grants the write this cycle
- rf_we  out  1  head requests an RF write
- rf_waddr  out  ADDR_W  head dest
- rf_wdata  out  DATA_W  head result
- fwd_raddr  in  NFWD*ADDR_W  lookup addresses, port i at bits [i*ADDR_W +: ADDR_W]
- fwd_hit  out  NFWD  pending write to that address exists
- fwd_data  out  NFWD*DATA_W  youngest pending result per port
- wb_count  out  $clog2(DEPTH)+1  occupied entries
- debug_wb_pc  out  DATA_W  pc of entry retiring this cycle
- debug_wb_rf_we  out  4  {4{committed RF write}}
- debug_wb_rf_wnum  out  ADDR_W  dest of retiring entry
- debug_wb_rf_wdata  out  DATA_W  result of retiring entry

Behaviour:
- Reset: head, tail and count are 0 and all entry valid bits are cleared. While empty, rf_we=0, fwd_hit=0, debug_wb_rf_we=0 and WB_allow_in=1.
- Data outputs when empty (rf_waddr/wdata, fwd_data, debug pc/wnum/wdata) are don't-care for checking.
- Enqueue: occurs when MEM_to_WB_valid && WB_allow_in && !flush. The entry is written at tail, tail wraps modulo DEPTH.
- The entry is visible at head and to forwarding the next cycle. Minimum latency, accept to retire, is 1 cycle.
- Head write eligibility: the head entry writes when valid && gr_we && dest!=0. rf_we equals that condition && !flush; rf_waddr and rf_wdata always show head fields.
- Retire: fires when head valid && !flush && (!eligible || rf_ready).
  - Entries with gr_we=0, or with dest=0, retire without waiting for rf_ready.
  - head advances, wrapping modulo DEPTH.
- Strictly in order; one retire per cycle max.
- WB_allow_in = (count<DEPTH) || retire. A full queue therefore accepts in the same cycle its head retires; this is a combinational path from rf_ready.
- Simultaneous enqueue and retire leaves count unchanged. Enqueue into an empty queue cannot retire in the same cycle.
- Forwarding, per port, combinational:
  - Searches valid entries with gr_we && dest==fwd_raddr[i] && dest!=0.
  - The youngest matching entry, closest to tail, supplies fwd_data.
  - The head entry matches even in the cycle it retires.
  - fwd_raddr=0 never hits.
- Debug: when retire fires, debug_wb_pc/wnum/wdata show the head entry and debug_wb_rf_we={4{rf_we && rf_ready}}. Otherwise debug_wb_rf_we=0.
- Flush:
  - In the flush cycle rf_we=0, there is no retire, no enqueue and debug_wb_rf_we=0.
  - Next cycle the queue is empty (head=tail, count=0).
  - flush together with reset behaves as reset.
- Reset mid-operation: all pending entries are dropped and no RF write is issued in the reset cycle.
- No RF write is ever issued twice for one entry. An entry stalled on rf_ready holds its outputs stable until granted.

Test Plan:
- Single pass-through: rf_ready=1; enqueue {pc=0x1c000000, dest=3, result=0xDEADBEEF, we=1} at cycle t. Required: rf_we=1, waddr=3, wdata=0xDEADBEEF and debug_wb_rf_we=4'hF at t+1 only; wb_count returns to 0 at t+2.
- Fill and backpressure: rf_ready=0; offer 5 writes to dest 1..5. Required: 4 accepted; WB_allow_in=0 with wb_count=4. Raise rf_ready: the same cycle accepts dest 5; retires proceed 1,2,3,4,5 in order, one per cycle.
- Forwarding youngest: rf_ready=0; enqueue dest 7 = 0x11, then dest 7 = 0x22. Required: fwd_raddr[0]=7 gives hit=1, data=0x22; fwd_raddr[1]=0 gives hit=0 even if a dest-0 entry is queued.
- Non-writing entries: rf_ready=0; enqueue gr_we=0 (pc=0x100) and dest=0, we=1 (pc=0x104). Required: both retire on consecutive cycles with debug_wb_rf_we=0 and rf_we never asserted.
- Flush: 3 pending entries, rf_ready=1, flush=1 for one cycle together with a valid offer. Required: rf_we=0 in that cycle; the offer is dropped; next cycle wb_count=0 and fwd_hit=0.
- Reset mid-stall: 2 entries pending with rf_ready=0; assert reset for one cycle. Required: after reset wb_count=0, rf_we=0 and WB_allow_in=1; raising rf_ready produces no write.
